// File: rtl/fdiv_issue_ctrl.sv
// fdiv_issue_ctrl
//   Issue-side controller for the single-precision FP divider. Tagged FDIV ops
//   from the reservation station are buffered in a small circular FIFO. They are
//   started on the divider one at a time, and each result is returned on the CDB
//   with RISC-V fflags and its ROB tag. A flush kills queued ops. A divide that
//   has already started cannot be aborted, so its result is drained and dropped.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
//   valid & ready are both 1. A producer holding valid=1 keeps its payload stable
//   until the transfer. in_valid/in_tag/in_a/in_b come from the RS, and in_ready
//   depends only on the queue count. cdb_valid and the cdb_* payload are
//   registered; cdb_ready may depend on anything.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kill queued and in-flight ops
//   in_valid/in_ready   op request handshake; in_a, in_b, in_tag are the payload
//   div_start           one-cycle start pulse to the divider
//   div_a, div_b        divider operands, held from START until done
//   div_done            divider completion, level or pulse
//   div_result          divider quotient
//   div_dz/of/uf        divider exception flags
//   cdb_valid/cdb_ready result handshake; cdb_result, cdb_fflags, cdb_tag are the payload
//   busy                queue non-empty or sequencer active
//   dbg_state           current sequencer state (IDLE=0 START=1 WAIT=2 RESP=3 DRAIN=4)
module fdiv_issue_ctrl #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic             div_done,
  input  logic [31:0]      div_result,
  input  logic             div_dz,
  input  logic             div_of,
  input  logic             div_uf,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [31:0]      cdb_result,
  output logic [4:0]       cdb_fflags,
  output logic [TAG_W-1:0] cdb_tag,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Op queue storage (data only; occupancy is tracked by count)
  logic [31:0]      q_a   [DEPTH];
  logic [31:0]      q_b   [DEPTH];
  logic [TAG_W-1:0] q_tag [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;

  logic             push, pop;
  logic             ign_done, done_ok, capture;
  logic [TAG_W-1:0] op_tag;

  assign in_ready  = (count < (PW+1)'(DEPTH));
  // An op offered in the same cycle as a flush is dropped.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = (state == S_IDLE) & (count != '0) & ~flush;
  assign div_start = (state == S_START);
  assign busy      = (count != '0) | (state != S_IDLE);
  assign dbg_state = state;

  // div_done may still be high from the previous op during the first cycle
  // after the start pulse, so it is ignored in that cycle. This applies to
  // both WAIT and DRAIN.
  assign done_ok = div_done & ~ign_done;

  // ---------------- queue ----------------
  always_ff @(posedge clk) begin
    if (push) begin
      q_a[wr_ptr]   <= in_a;
      q_b[wr_ptr]   <= in_b;
      q_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_START;
      S_START: state_nxt = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush) begin
          // If the divider finishes on the flush cycle there is nothing left
          // to drain.
          state_nxt = done_ok ? S_IDLE : S_DRAIN;
        end else if (done_ok) begin
          state_nxt = S_RESP;
          capture   = 1'b1;
        end
      end
      // cdb_valid is always 1 in RESP. A flush on the handshake cycle lets
      // the transfer complete.
      S_RESP:  if (cdb_ready || flush) state_nxt = S_IDLE;
      S_DRAIN: if (done_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ign_done   <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      op_tag     <= '0;
      cdb_valid  <= 1'b0;
      cdb_result <= '0;
      cdb_fflags <= '0;
      cdb_tag    <= '0;
    end else begin
      ign_done  <= (state == S_START);
      cdb_valid <= (state_nxt == S_RESP);
      if (pop) begin
        div_a  <= q_a[rd_ptr];
        div_b  <= q_b[rd_ptr];
        op_tag <= q_tag[rd_ptr];
      end
      if (capture) begin
        cdb_result <= div_result;
        // {NV, DZ, OF, UF, NX}: NV is never raised by this divider, and NX
        // accompanies any overflow or underflow.
        cdb_fflags <= {1'b0, div_dz, div_of, div_uf, div_of | div_uf};
        cdb_tag    <= op_tag;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Bench for fdiv_issue_ctrl. A behavioural divider answers div_start with a
// result taken from a table of known IEEE-754 quotients. A CDB monitor pops
// expected {tag, fflags, result} entries and compares them against the output.
module tb_fdiv_issue_ctrl;

  localparam int TAG_W = 6;
  localparam int DEPTH = 2;
  localparam int EW    = TAG_W + 5 + 32;
  localparam int NTAB  = 7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0, in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             div_start;
  logic [31:0]      div_a, div_b;
  logic             div_done = 1'b0;
  logic [31:0]      div_result = '0;
  logic             div_dz = 1'b0, div_of = 1'b0, div_uf = 1'b0;
  logic             cdb_valid;
  logic             cdb_ready = 1'b1;
  logic [31:0]      cdb_result;
  logic [4:0]       cdb_fflags;
  logic [TAG_W-1:0] cdb_tag;
  logic             busy;
  logic [2:0]       dbg_state;

  fdiv_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_result(div_result),
    .div_dz(div_dz), .div_of(div_of), .div_uf(div_uf),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_result(cdb_result),
    .cdb_fflags(cdb_fflags), .cdb_tag(cdb_tag),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- reference table ----------------
  // The fflags column is the expected {NV,DZ,OF,UF,NX}.
  // The divider model raises DZ/OF/UF from bits 3..1 of that column.
  logic [31:0] t_a   [NTAB] = '{32'h41200000, 32'h3F800000, 32'h40A00000, 32'h7F7FFFFF,
                                32'h00800000, 32'h40400000, 32'hC0000000};
  logic [31:0] t_b   [NTAB] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h3F000000,
                                32'h7F000000, 32'h3F800000, 32'h40800000};
  logic [31:0] t_q   [NTAB] = '{32'h40A00000, 32'h3EAAAAAB, 32'h7F800000, 32'h7F800000,
                                32'h00000000, 32'h40400000, 32'hBF000000};
  logic [4:0]  t_fl  [NTAB] = '{5'b00000, 5'b00000, 5'b01000, 5'b00101,
                                5'b00011, 5'b00000, 5'b00000};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  int n_cdb = 0;
  int force_lat = 0;     // 0: random divider latency
  bit level_mode = 1'b0; // div_done stays high until after the next start
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NTAB; i++)
      if (t_a[i] == a && t_b[i] == b) return i;
    return -1;
  endfunction

  // ---------------- divider model ----------------
  initial begin : div_model
    int elapsed, lat, idx;
    bit active, pulse_armed;
    logic [31:0] ca, cb;
    active = 0; pulse_armed = 0; elapsed = 0; lat = 2; ca = '0; cb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; pulse_armed = 0;
        div_done = 1'b0; div_dz = 1'b0; div_of = 1'b0; div_uf = 1'b0;
      end else if (div_start) begin
        n_starts++;
        ca = div_a; cb = div_b;
        active = 1; pulse_armed = 0; elapsed = 0;
        lat = (force_lat != 0) ? force_lat : $urandom_range(2, 5);
      end else if (active) begin
        elapsed++;
        check("div_a_hold", div_a, ca);
        check("div_b_hold", div_b, cb);
        if (elapsed == lat) begin
          idx = lookup(ca, cb);
          div_done = 1'b1;
          if (idx < 0) begin
            div_result = 32'hDEADBEEF;
            {div_dz, div_of, div_uf} = 3'b000;
          end else begin
            div_result = t_q[idx];
            div_dz = t_fl[idx][3]; div_of = t_fl[idx][2]; div_uf = t_fl[idx][1];
          end
          active = 0;
          pulse_armed = !level_mode;
        end else if (elapsed >= 2) begin
          div_done = 1'b0;
        end
      end else if (pulse_armed) begin
        div_done = 1'b0;
        pulse_armed = 0;
      end
    end
  end

  // ---------------- CDB monitor ----------------
  initial begin : cdb_mon
    bit hold_p;
    logic [EW:0] prev;
    logic [EW-1:0] e;
    hold_p = 0; prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold_p = 0;
      end else begin
        if (hold_p) check("cdb_hold", {cdb_valid, cdb_tag, cdb_fflags, cdb_result}, prev);
        if (cdb_valid && cdb_ready) begin
          n_cdb++;
          if (exp_q.size() == 0) begin
            check("cdb_extra", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("cdb_tag", cdb_tag, e[EW-1 -: TAG_W]);
            check("cdb_fflags", cdb_fflags, e[36:32]);
            check("cdb_result", cdb_result, e[31:0]);
          end
        end
        hold_p = cdb_valid && !cdb_ready && !flush;
        prev = {cdb_valid, cdb_tag, cdb_fflags, cdb_result};
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(negedge clk);
      if (rand_rdy) cdb_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic push_op(input int idx, input logic [TAG_W-1:0] tag);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_a = t_a[idx]; in_b = t_b[idx]; in_tag = tag;
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("push_timeout", 64'(guard), 64'd0);
    else exp_q.push_back({tag, t_fl[idx], t_q[idx]});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk); #3; guard++;
    end while ((busy || exp_q.size() != 0) && guard < 400);
    if (guard >= 400) check(tag, {busy, 32'(exp_q.size())}, 64'd0);
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk); #2; guard++;
    end while (dbg_state != st && guard < 100);
    if (dbg_state != st) check(tag, dbg_state, st);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, div_start, 1'b0);
    check({tag, "_div_a"}, div_a, 32'h0);
    check({tag, "_div_b"}, div_b, 32'h0);
    check({tag, "_cdb_valid"}, cdb_valid, 1'b0);
    check({tag, "_cdb_result"}, cdb_result, 32'h0);
    check({tag, "_cdb_fflags"}, cdb_fflags, 5'h0);
    check({tag, "_cdb_tag"}, cdb_tag, 6'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int guard;
    #12;
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1'b1);

    // 1: 10/2, tag 3, latency and single start pulse
    @(negedge clk);
    push_op(0, 6'd3);
    #2 check("t1_start_c1", div_start, 1'b0);
    @(negedge clk); #2 check("t1_start_c2", div_start, 1'b1);
    @(negedge clk); #2 check("t1_start_c3", div_start, 1'b0);
    guard = 0;
    while (!div_done && guard < 20) begin
      @(negedge clk); #2; guard++;
    end
    check("t1_done_seen", div_done, 1'b1);
    check("t1_valid_before", cdb_valid, 1'b0);
    @(negedge clk); #2 check("t1_valid_after", cdb_valid, 1'b1);
    wait_idle("t1_idle");
    check("t1_nstarts", 64'(n_starts), 64'd1);

    // 2..4 plus underflow and two ordinary vectors, stale level done between ops
    level_mode = 1'b1;
    @(negedge clk);
    push_op(1, 6'd4);
    push_op(2, 6'd5);
    push_op(3, 6'd6);
    push_op(4, 6'd8);
    push_op(6, 6'd10);
    wait_idle("t2_idle");

    // 5: queue fill with the CDB stalled, then in-order delivery
    @(negedge clk);
    cdb_ready = 1'b0;
    push_op(0, 6'd3);
    push_op(5, 6'd7);
    push_op(1, 6'd11);
    #2 check("t5_full_ready", in_ready, 1'b0);
    guard = 0;
    while (!cdb_valid && guard < 30) begin
      @(negedge clk); #2; guard++;
    end
    check("t5_valid", cdb_valid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_tag", cdb_tag, 6'd3);
      check("t5_hold_ready", in_ready, 1'b0);
      @(negedge clk); #2;
    end
    cdb_ready = 1'b1;
    push_op(6, 6'd13);
    wait_idle("t5_idle");

    // 6: flush in WAIT with another op queued and a new op offered on the flush cycle
    force_lat = 5;
    @(negedge clk);
    push_op(0, 6'd5);
    push_op(1, 6'd9);
    wait_state(ST_WAIT, "t6_reach_wait");
    flush = 1'b1;
    in_valid = 1'b1; in_a = t_a[5]; in_b = t_b[5]; in_tag = 6'd12;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #2;
    check("t6_drain", dbg_state, ST_DRAIN);
    check("t6_busy", busy, 1'b1);
    check("t6_in_ready", in_ready, 1'b1);
    wait_state(ST_IDLE, "t6_drain_exit");
    check("t6_no_cdb_busy", busy, 1'b0);
    push_op(5, 6'd2);
    wait_idle("t6_idle");

    // Flush in START: stale done in the first DRAIN cycle must not end the drain
    force_lat = 4;
    @(negedge clk);
    push_op(3, 6'd20);
    wait_state(ST_START, "t7_reach_start");
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    #2 check("t7_drain1", dbg_state, ST_DRAIN);
    @(negedge clk); #2 check("t7_drain2", dbg_state, ST_DRAIN);
    wait_state(ST_IDLE, "t7_drain_exit");
    force_lat = 0;
    push_op(2, 6'd21);
    wait_idle("t7_idle");

    // Random traffic with random CDB back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      level_mode = 1'($urandom_range(0, 1));
      push_op($urandom_range(0, NTAB-1), 6'($urandom_range(0, 63)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    cdb_ready = 1'b1;
    wait_idle("rand_idle");

    // Reset while WAIT
    force_lat = 5;
    @(negedge clk);
    push_op(1, 6'd30);
    wait_state(ST_WAIT, "rst_reach_wait");
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    force_lat = 0;
    #2 check("rst_mid_in_ready", in_ready, 1'b1);
    @(negedge clk);
    push_op(0, 6'd31);
    wait_idle("post_rst_idle");

    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
